pipe_stage_hs: RTL and testbench



---
 rtl/core_pipe_pkg.sv | 45 ++++
 rtl/pipe_stage_hs_if.sv | 38 +++
 rtl/pipe_entry.sv | 56 +++++
 rtl/pipe_stage_hs.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_hs.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/core_pipe_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
// Shared constants and types for the core's inter-stage pipeline registers.
//   INST_NOP      : canonical NOP instruction (addi x0, x0, 0).
//   CNT_W         : width of the stage occupancy count.
//   IDEX_*        : bit offsets used to pack/unpack the ID->EX payload.
//   id_ex_t       : packed view of the ID->EX payload, laid out to match
//                   the IDEX_* offsets (inst in the LSBs).
//   id_ex_pack / id_ex_unpack : helpers between fields and the flat payload.
// ---------------------------------------------------------------------------
package core_pipe_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int          CNT_W    = 2;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // ID->EX payload layout, LSB first.
    localparam int IDEX_INST_LSB = 0;
    localparam int IDEX_ADDR_LSB = IDEX_INST_LSB + XLEN;
    localparam int IDEX_OPA_LSB  = IDEX_ADDR_LSB + XLEN;
    localparam int IDEX_OPB_LSB  = IDEX_OPA_LSB + XLEN;
    localparam int IDEX_RD_LSB   = IDEX_OPB_LSB + XLEN;
    localparam int IDEX_WEN_BIT  = IDEX_RD_LSB + REG_AW;
    localparam int IDEX_WIDTH    = IDEX_WEN_BIT + 1;

    typedef struct packed {
        logic              reg_wen;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   inst_addr;
        logic [XLEN-1:0]   inst;
    } id_ex_t;

    function automatic logic [IDEX_WIDTH-1:0] id_ex_pack(input id_ex_t f);
        return f;
    endfunction

    function automatic id_ex_t id_ex_unpack(input logic [IDEX_WIDTH-1:0] p);
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs_if
// Signal bundle around one pipeline stage register.
//   valid_i/data_i/ready_o : upstream handshake (into the stage)
//   valid_o/data_o/ready_i : downstream handshake (out of the stage)
//   stall_i/flush_i        : controls from ctrl
//   count_o                : entries currently held
// Modports:
//   slave  : the stage itself
//   master : the environment around it (upstream, downstream and ctrl)
// ---------------------------------------------------------------------------
interface pipe_stage_hs_if
    import core_pipe_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             stall_i;
    logic             flush_i;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  valid_i, data_i, ready_i, stall_i, flush_i,
        output ready_o, valid_o, data_o, count_o
    );

    modport master (
        output valid_i, data_i, ready_i, stall_i, flush_i,
        input  ready_o, valid_o, data_o, count_o
    );

endinterface

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One pipeline slot: WIDTH-bit data register plus valid bit.
//   clk, rst_n : clock, asynchronous active-low reset (to RST_VALUE, invalid)
//   load_i     : capture data_i and mark the slot valid
//   clear_i    : synchronous clear to RST_VALUE/invalid; wins over load_i
//   data_i     : payload to capture
//   valid_o    : slot holds a payload
//   data_o     : held payload (RST_VALUE when cleared)
// ---------------------------------------------------------------------------
module pipe_entry #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = RST_VALUE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
// Handshaked pipeline register between core stages (IF->ID, ID->EX, EX->MEM).
// Carries one WIDTH-bit payload with valid/ready flow control, plus stall and
// flush controls from ctrl. An empty or flushed stage shows NOP_VALUE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_stage_hs_if.slave
//                valid_i/data_i/ready_o  upstream handshake
//                valid_o/data_o/ready_i  downstream handshake
//                stall_i                 freeze stage contents
//                flush_i                 discard everything held (beats stall)
//                count_o                 entries held (0..2)
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   : adds a skid entry; ready_o depends only on state and stall_i.
//   undefined : single entry; ready_o combinationally follows ready_i.
// ---------------------------------------------------------------------------
module pipe_stage_hs
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(INST_NOP)
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_hs_if.slave   bus
);

    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_load;
    logic             m_clear;
    logic [WIDTH-1:0] m_load_data;
    logic             s_valid;

    logic             ready;
    logic             in_xfer;
    logic             out_xfer;
    logic             valid_out;

    // Outputs seen by both neighbours.
    assign valid_out = m_valid & ~bus.stall_i;
    assign in_xfer   = bus.valid_i & ready;
    assign out_xfer  = valid_out & bus.ready_i;

    pipe_entry #(
        .WIDTH     (WIDTH),
        .RST_VALUE (NOP_VALUE)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (m_load),
        .clear_i (m_clear),
        .data_i  (m_load_data),
        .valid_o (m_valid),
        .data_o  (m_data)
    );

`ifdef PIPE_STAGE_SKID_EN

    logic             s_load;
    logic             s_clear;
    logic [WIDTH-1:0] s_data;
    logic             main_free;

    pipe_entry #(
        .WIDTH     (WIDTH),
        .RST_VALUE (NOP_VALUE)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (s_load),
        .clear_i (s_clear),
        .data_i  (bus.data_i),
        .valid_o (s_valid),
        .data_o  (s_data)
    );

    // Ready comes from registered state only: while the skid is empty there
    // is always room for one more beat, even if downstream stops this cycle.
    assign ready = ~s_valid & ~bus.stall_i;

    always_comb begin
        main_free   = ~m_valid | out_xfer;
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_load_data = bus.data_i;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (bus.flush_i) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (!bus.stall_i) begin
            if (main_free) begin
                // The skid holds the older beat, so it drains first.
                if (s_valid) begin
                    m_load      = 1'b1;
                    m_load_data = s_data;
                    s_clear     = 1'b1;
                end else if (in_xfer) begin
                    m_load = 1'b1;
                end else begin
                    m_clear = 1'b1;
                end
            end else if (in_xfer) begin
                s_load = 1'b1;
            end
        end
    end

`else

    assign s_valid = 1'b0;

    // Downstream acceptance frees the main entry in the same cycle, so ready
    // has a combinational path from ready_i.
    assign ready = (~m_valid | bus.ready_i) & ~bus.stall_i;

    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_load_data = bus.data_i;
        if (bus.flush_i) begin
            m_clear = 1'b1;
        end else if (in_xfer) begin
            m_load = 1'b1;
        end else if (out_xfer) begin
            m_clear = 1'b1;
        end
    end

`endif

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_out;
    assign bus.data_o  = m_valid ? m_data : NOP_VALUE;
    assign bus.count_o = CNT_W'(m_valid) + CNT_W'(s_valid);

    // The skid may only hold a payload behind an occupied main entry.
    a_skid_behind_main : assert property (
        @(posedge clk) disable iff (!rst_n) s_valid |-> m_valid
    ) else $error("pipe_stage_hs: skid entry valid while main entry empty");

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_hs
// Directed bench for pipe_stage_hs. An upstream source queue feeds the stage;
// a scoreboard queue holds the payloads the stage should currently contain,
// in order. Each step drives inputs on the falling edge, checks outputs
// shortly after, then advances the scoreboard by the expected handshakes.
// Builds with or without PIPE_STAGE_SKID_EN (capacity 2 or 1).
// ---------------------------------------------------------------------------
module tb_pipe_stage_hs;
    import core_pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;

    pipe_stage_hs_if #(.WIDTH(32)) bus ();

    pipe_stage_hs #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    logic [31:0] exp_q[$];   // payloads expected inside the stage, oldest first
    logic [31:0] src_q[$];   // payloads waiting upstream

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input logic ri, input logic st, input logic fl, input logic ven);
        logic        vi;
        logic [31:0] di;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic        acc;
        logic        leave;
        vi = ven && (src_q.size() > 0);
        di = vi ? src_q[0] : $urandom;
        bus.valid_i = vi;
        bus.data_i  = di;
        bus.ready_i = ri;
        bus.stall_i = st;
        bus.flush_i = fl;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        e_ready = (exp_q.size() < 2) && !st;
`else
        e_ready = ((exp_q.size() == 0) || ri) && !st;
`endif
        e_valid = (exp_q.size() > 0) && !st;
        e_data  = (exp_q.size() > 0) ? exp_q[0] : NOP;
        chk("ready_o", {31'b0, bus.ready_o}, {31'b0, e_ready});
        chk("valid_o", {31'b0, bus.valid_o}, {31'b0, e_valid});
        chk("data_o",  bus.data_o, e_data);
        chk("count_o", {30'b0, bus.count_o}, exp_q.size());
        acc   = vi && e_ready;
        leave = e_valid && ri;
        if (acc) void'(src_q.pop_front());
        if (fl) begin
            exp_q.delete();
        end else begin
            if (leave) void'(exp_q.pop_front());
            if (acc)   exp_q.push_back(di);
        end
        @(posedge clk);
        @(negedge clk);
        step_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset with junk on the inputs ----
        rst_n       = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 32'hDEAD_BEEF;
        bus.ready_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_data_o",  bus.data_o, NOP);
        chk("rst_count_o", {30'b0, bus.count_o}, 32'd0);
        chk("rst_ready_o", {31'b0, bus.ready_o}, 32'd1);
        bus.stall_i = 1'b1;
        #1;
        chk("rst_ready_stalled", {31'b0, bus.ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- first accept appears one cycle later ----
        src_q.push_back(32'h0000_00A0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // ---- streaming 1..8 back-to-back ----
        for (int i = 1; i <= 8; i++) src_q.push_back(i);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // ---- back-pressure: A, B, C while downstream is stopped ----
        src_q.push_back(32'h0000_000A);
        src_q.push_back(32'h0000_000B);
        src_q.push_back(32'h0000_000C);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // ---- stall with 12345678 held ----
        src_q.push_back(32'h1234_5678);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // ---- flush with a full stage, stall and a valid input together ----
        src_q.push_back(32'h0000_1111);
        src_q.push_back(32'h0000_2222);
        src_q.push_back(32'h0BAD_0BAD);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        src_q.delete();
        idle(2);

        // ---- flush that drops a beat accepted in the same cycle ----
        src_q.push_back(32'h0000_F00D);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // ---- ready_i toggling with a continuous source ----
        for (int i = 0; i < 12; i++) src_q.push_back(32'h0000_0100 + i);
        for (int i = 0; i < 16; i++) step(i[0], 1'b0, 1'b0, 1'b1);
        src_q.delete();
        idle(3);

        // ---- asynchronous reset mid-operation ----
        src_q.push_back(32'h0000_0A5A);
        src_q.push_back(32'h0000_05A5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        bus.valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("async_rst_data_o",  bus.data_o, NOP);
        chk("async_rst_count_o", {30'b0, bus.count_o}, 32'd0);
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // ---- mixed traffic ----
        for (int i = 0; i < 80; i++) begin
            if (src_q.size() < 3) src_q.push_back($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        src_q.delete();
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
